// File: rtl/wave_sequencer.sv
// Four-entry step-table waveform sequencer playing square or rest steps on an 8-bit output.
// Optional macro WAVE_SEQ_LOOP_EN adds a loop input that replays the table until stop.
module wave_sequencer #(
    parameter int HPW = 8,
    parameter int CW  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_addr,
    input  logic [CW+HPW:0]   cfg_data,
    input  logic [2:0]        num_steps,
    input  logic              start,
    input  logic              stop,
`ifdef WAVE_SEQ_LOOP_EN
    input  logic              loop,
`endif
    output logic              busy,
    output logic              done,
    output logic [1:0]        step_idx,
    output logic [7:0]        wave
);

    localparam int DW = CW + HPW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_r;
    logic [DW-1:0]   table_r [4];
    logic [1:0]      last_idx_r;
    logic            mode_r;
    logic            phase_r;
    logic [HPW-1:0]  hp_r;
    logic [HPW-1:0]  hp_cnt_r;
    logic [CW-1:0]   cyc_cnt_r;

    logic [DW-1:0]   entry_s;
    logic            ent_mode_s;
    logic [CW-1:0]   ent_cycles_s;
    logic [HPW-1:0]  ent_hp_s;
    logic [HPW-1:0]  ent_hpm1_s;
    logic            start_ok_s;
    logic [1:0]      last_idx_s;
    logic            last_step_s;
    logic            loop_s;
    logic            adv_done_s;
    logic [1:0]      adv_idx_s;
    logic            step_end_s;
    logic            to_done_s;

    // Decode the current table entry and derive step-advance / abort decisions.
    always_comb begin
        entry_s      = table_r[step_idx];
        ent_mode_s   = entry_s[DW-1];
        ent_cycles_s = entry_s[DW-2:HPW];
        ent_hp_s     = entry_s[HPW-1:0];
        // Phase counters run down to zero, so store half_period-1; zero behaves as one.
        if (ent_hp_s == {HPW{1'b0}}) begin
            ent_hpm1_s = {HPW{1'b0}};
        end else begin
            ent_hpm1_s = ent_hp_s - HPW'(1);
        end
`ifdef WAVE_SEQ_LOOP_EN
        loop_s = loop;
`else
        loop_s = 1'b0;
`endif
        start_ok_s  = start && (num_steps != 3'd0) && (num_steps <= 3'd4);
        last_idx_s  = 2'(num_steps - 3'd1);
        last_step_s = (step_idx == last_idx_r);
        adv_done_s  = last_step_s && !loop_s;
        if (last_step_s) begin
            adv_idx_s = 2'd0;
        end else begin
            adv_idx_s = step_idx + 2'd1;
        end
        if (state_r == S_LOAD) begin
            step_end_s = (ent_cycles_s == {CW{1'b0}});
        end else if (state_r == S_RUN) begin
            step_end_s = (hp_cnt_r == {HPW{1'b0}}) && !phase_r && (cyc_cnt_r == {CW{1'b0}});
        end else begin
            step_end_s = 1'b0;
        end
        if ((state_r == S_LOAD) || (state_r == S_RUN)) begin
            to_done_s = stop || (step_end_s && adv_done_s);
        end else begin
            to_done_s = 1'b0;
        end
    end

    // Sequencer state, step table, phase counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= S_IDLE;
            for (int i = 0; i < 4; i++) begin
                table_r[i] <= {DW{1'b0}};
            end
            last_idx_r <= 2'd0;
            mode_r     <= 1'b0;
            phase_r    <= 1'b0;
            hp_r       <= {HPW{1'b0}};
            hp_cnt_r   <= {HPW{1'b0}};
            cyc_cnt_r  <= {CW{1'b0}};
            busy       <= 1'b0;
            done       <= 1'b0;
            step_idx   <= 2'd0;
            wave       <= 8'h00;
        end else begin
            if (cfg_we && (state_r == S_IDLE)) begin
                table_r[cfg_addr] <= cfg_data;
            end
            done <= 1'b0;
            if (to_done_s) begin
                state_r  <= S_DONE;
                done     <= 1'b1;
                busy     <= 1'b0;
                wave     <= 8'h00;
                step_idx <= 2'd0;
            end else if (step_end_s) begin
                state_r  <= S_LOAD;
                step_idx <= adv_idx_s;
            end else begin
                case (state_r)
                    S_IDLE: begin
                        if (start_ok_s) begin
                            state_r    <= S_LOAD;
                            busy       <= 1'b1;
                            step_idx   <= 2'd0;
                            last_idx_r <= last_idx_s;
                        end
                    end
                    S_LOAD: begin
                        state_r   <= S_RUN;
                        mode_r    <= ent_mode_s;
                        hp_r      <= ent_hpm1_s;
                        hp_cnt_r  <= ent_hpm1_s;
                        cyc_cnt_r <= ent_cycles_s - CW'(1);
                        phase_r   <= 1'b1;
                        wave      <= ent_mode_s ? 8'h00 : 8'hFF;
                    end
                    S_RUN: begin
                        if (hp_cnt_r != {HPW{1'b0}}) begin
                            hp_cnt_r <= hp_cnt_r - HPW'(1);
                        end else if (phase_r) begin
                            phase_r  <= 1'b0;
                            wave     <= 8'h00;
                            hp_cnt_r <= hp_r;
                        end else begin
                            cyc_cnt_r <= cyc_cnt_r - CW'(1);
                            phase_r   <= 1'b1;
                            wave      <= mode_r ? 8'h00 : 8'hFF;
                            hp_cnt_r  <= hp_r;
                        end
                    end
                    S_DONE: begin
                        state_r <= S_IDLE;
                    end
                    default: begin
                        state_r  <= S_IDLE;
                        busy     <= 1'b0;
                        step_idx <= 2'd0;
                        wave     <= 8'h00;
                    end
                endcase
            end
        end
    end

endmodule
